// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit between the single-cycle core and data memory.
// Checks alignment and funct3 legality, then drives a word-addressed,
// byte-enabled memory port with a variable-latency ack handshake. It returns
// sign- or zero-extended load data and stalls the core while busy.
// Optional feature: define LSU_TIMEOUT_EN to abort a bus access after
// TIMEOUT cycles without mem_ack_i.
module lsu_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        req_ready_o,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        stall_o,
  output logic        mem_ce_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t      state, state_nxt;
  logic        accept;
  logic        req_err;
  logic [3:0]  req_be;
  logic [31:0] req_wdata_rep;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [31:0] load_data;
  logic        tmo_hit;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] tmo_cnt;
  assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  assign accept = (state == IDLE) && req_valid_i;

  // Request decode: legality, byte enables and lane-replicated store data
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
    req_err       = 1'b0;
    req_be        = 4'b0000;
    req_wdata_rep = req_wdata_i;
    if (req_we_i) req_err = (req_funct3_i >= 3'd3);
    else          req_err = (req_funct3_i == 3'd3) || (req_funct3_i[2:1] == 2'b11);
    if ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0])               req_err = 1'b1;
    if ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00))  req_err = 1'b1;
    case (req_funct3_i[1:0])
      2'b00: begin
        req_be        = 4'b0001 << req_addr_i[1:0];
        req_wdata_rep = {4{req_wdata_i[7:0]}};
      end
      2'b01: begin
        req_be        = 4'b0011 << req_addr_i[1:0];
        req_wdata_rep = {2{req_wdata_i[15:0]}};
      end
      default: req_be = 4'b1111;
    endcase
    // Loads read the whole word; enables only qualify store lanes
    if (!req_we_i) begin
      req_be        = 4'b0000;
      req_wdata_rep = 32'h0;
    end
  end

  // Load alignment and extension of the returned word
  always_comb begin
    logic [31:0] shifted;
    shifted = mem_rdata_i >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {24'h0, shifted[7:0]};
      3'b101:  load_data = {16'h0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid_i) state_nxt = req_err ? RESP : BUS;
      BUS:     if (mem_ack_i || tmo_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM-decoded outputs
  always_comb begin
    req_ready_o  = (state == IDLE);
    mem_ce_o     = (state == BUS);
    resp_valid_o = (state == RESP);
  end

  assign stall_o = req_valid_i & ~resp_valid_o;

  // Request latch, memory port registers and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      funct3_q     <= 3'b000;
      off_q        <= 2'b00;
      mem_we_o     <= 1'b0;
      mem_be_o     <= 4'b0000;
      mem_addr_o   <= 32'h0;
      mem_wdata_o  <= 32'h0;
      resp_rdata_o <= 32'h0;
      resp_err_o   <= 1'b0;
    end else begin
      if (accept) begin
        funct3_q <= req_funct3_i;
        off_q    <= req_addr_i[1:0];
        if (req_err) begin
          // Faulting requests never touch memory and answer straight away
          resp_err_o   <= 1'b1;
          resp_rdata_o <= 32'h0;
        end else begin
          mem_we_o    <= req_we_i;
          mem_be_o    <= req_be;
          mem_addr_o  <= {req_addr_i[31:2], 2'b00};
          mem_wdata_o <= req_wdata_rep;
        end
      end
      if (state == BUS) begin
        if (mem_ack_i) begin
          resp_err_o   <= 1'b0;
          resp_rdata_o <= mem_we_o ? 32'h0 : load_data;
        end else if (tmo_hit) begin
          resp_err_o   <= 1'b1;
          resp_rdata_o <= 32'h0;
        end
      end
    end
  end

`ifdef LSU_TIMEOUT_EN
  // Bus watchdog: counts unacknowledged BUS cycles, cleared on BUS entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         tmo_cnt <= '0;
    else if (accept)                 tmo_cnt <= '0;
    else if ((state == BUS) && !mem_ack_i) tmo_cnt <= tmo_cnt + 1'b1;
  end
`endif

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store unit between the single-cycle `riscv` core and data memory. Takes one memory request per load/store instruction and checks alignment. Drives a word-addressed, byte-enabled memory port with a variable-latency `mem_ack_i` handshake, then returns sign- or zero-extended load data. It holds the core through `stall_o` while the access is in flight, replacing the core's direct `data_*` wiring.

## Interface
Parameters:
- `TIMEOUT`, default 16: bus cycles without `mem_ack_i` before abort. Used only with `LSU_TIMEOUT_EN`.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous active-high reset
- `req_valid_i`  in  1  core has a load/store this instruction
- `req_we_i`  in  1  1 = store, 0 = load
- `req_funct3_i`  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- `req_addr_i`  in  32  byte address
- `req_wdata_i`  in  32  store data (rs2)
- `req_ready_o`  out  1  unit can accept a request
- `resp_valid_o`  out  1  one-cycle completion pulse
- `resp_rdata_o`  out  32  extended load data, 0 for stores/errors
- `resp_err_o`  out  1  misaligned, illegal funct3 or timeout; qualified by `resp_valid_o`
- `stall_o`  out  1  core must hold PC and request inputs
- `mem_ce_o`  out  1  memory request
- `mem_we_o`  out  1  memory write
- `mem_be_o`  out  4  byte enables
- `mem_addr_o`  out  32  word address, bits [1:0] = 0
- `mem_wdata_o`  out  32  lane-replicated store data
- `mem_rdata_i`  in  32  memory read word
- `mem_ack_i`  in  1  memory completed access this cycle

## Operation
- States: IDLE, BUS, RESP. Reset → IDLE.
- IDLE: `req_ready_o`=1. On `req_valid_i`, latch we/funct3/addr/wdata.
  - Error check: halfword with addr[0]=1, or word with addr[1:0]≠0 → misaligned. Loads with funct3 ∈ {3,6,7} or stores with funct3 ≥ 3 → illegal.
  - On error: go to RESP with err=1. Memory is never touched.
  - Otherwise go to BUS.
- BUS: `mem_ce_o`=1. `mem_we_o`, `mem_be_o`, `mem_addr_o`, `mem_wdata_o` are registered and stable until ack.
  - On `mem_ack_i`: capture data, go to RESP.
- Byte enables: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<addr[1:0]; word = 4'b1111.
- Store data: SB → {4{wdata[7:0]}}; SH → {2{wdata[15:0]}}; SW → wdata.
- Load data: shift `mem_rdata_i` right by 8·addr[1:0], then extend from bit 7 (LB), bit 15 (LH), zero-extend (LBU/LHU), or pass through (LW).
- RESP: `resp_valid_o`=1 for exactly one cycle, then back to IDLE.
- `stall_o` = `req_valid_i` & ~`resp_valid_o` (combinational). The core advances on the edge where `resp_valid_o`=1.
- `mem_ack_i` in IDLE or RESP is ignored.

## Timing
- Reset values: state IDLE; `req_ready_o`=1; all other outputs 0; latched registers 0.
- Accept at cycle T. `mem_ce_o` high from T+1. An ack at T+1+k gives `resp_valid_o` at T+2+k.
  - Zero-wait memory: 2-cycle latency.
- Error request: accepted at T, `resp_valid_o` at T+1, `mem_ce_o` never asserted.
- At most one request in flight. `req_ready_o`=0 in BUS and RESP; `req_valid_i` is not sampled there.
- Reset asserted mid-BUS: `mem_ce_o` and all outputs drop asynchronously. No response is generated.
- `resp_rdata_o`/`resp_err_o` are registered and hold until the next RESP entry or reset.

## Configuration
- `LSU_TIMEOUT_EN` defined:
  - A counter clears on BUS entry and increments each BUS cycle without ack.
  - When it reaches `TIMEOUT`, drop `mem_ce_o` and go to RESP with `resp_err_o`=1 and `resp_rdata_o`=0.
  - An ack in the same cycle as the count reaching `TIMEOUT` wins (normal completion).
- `LSU_TIMEOUT_EN` undefined: no counter. BUS waits indefinitely, and `resp_err_o` covers only misaligned/illegal requests.

## Test plan
- LB at 0x1003, mem word 0x80FF_1234, ack at first BUS cycle → `mem_addr_o`=0x1000, `mem_be_o`=0000 (load), `resp_rdata_o`=0xFFFF_FF80, `resp_valid_o` 2 cycles after accept.
- SH at 0x2002, wdata 0xDEAD_BEEF → `mem_we_o`=1, `mem_be_o`=1100, `mem_wdata_o`=0xBEEF_BEEF, `resp_rdata_o`=0, err=0.
- LW at 0x3001 → no `mem_ce_o`; `resp_valid_o`+`resp_err_o` one cycle after accept; `stall_o` high exactly 1 cycle.
- LHU at 0x4002 with ack delayed 3 cycles, mem 0xA5A5_0000 → address/enables stable 4 BUS cycles, `resp_rdata_o`=0x0000_A5A5, `stall_o` high 5 cycles.
- `rst` pulsed mid-BUS → `mem_ce_o`=0 immediately, state IDLE, `req_ready_o`=1, no `resp_valid_o`. A subsequent SW completes normally.
- With `LSU_TIMEOUT_EN`, `TIMEOUT`=16, no ack → `mem_ce_o` high 16 cycles, then `resp_err_o`=1. Variant: ack on cycle 16 → normal completion, err=0.
